// File: rtl/dms_pkg.sv
// Shared types and constants for the SAM front-end sequencer: the FSM state
// encoding, key/exponent widths and the pulse-width ratios of a data symbol.
package dms_pkg;

  localparam int DMS_KEY_W = 32;
  localparam int DMS_N_W   = 4;
  localparam int DMS_MAX_N = 5;
  localparam int DMS_CNT_W = 6;

  // Zero-run share of a symbol: numerator over DMS_RATIO_DEN, per bit value.
  localparam int DMS_RATIO_DEN  = 4;
  localparam int DMS_RATIO_ONE  = 1;
  localparam int DMS_RATIO_ZERO = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_N,
    ST_LOAD_D,
    ST_LOAD_C,
    ST_LOAD_END,
    ST_DATA_IDLE,
    ST_SYM_LO,
    ST_SYM_HI
  } dms_state_t;

  // Last index of a 2^n-bit key field, computed in counter width.
  function automatic logic [DMS_CNT_W-1:0] dms_key_last(input logic [DMS_N_W-1:0] n);
    return (DMS_CNT_W'(1) << n) - DMS_CNT_W'(1);
  endfunction

  function automatic logic dms_is_load(input dms_state_t s);
    return (s == ST_LOAD_N) || (s == ST_LOAD_D) || (s == ST_LOAD_C) || (s == ST_LOAD_END);
  endfunction

  function automatic logic dms_is_data(input dms_state_t s);
    return (s == ST_DATA_IDLE) || (s == ST_SYM_LO) || (s == ST_SYM_HI);
  endfunction

endpackage

// File: rtl/dms_sym_encoder.sv
// Data-phase symbol timing: turns an accepted message bit into a zero run and
// a one run, and flags the last cycle of each symbol for back-to-back chaining.
module dms_sym_encoder
  import dms_pkg::*;
#(
  parameter int SYM_LEN = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  dms_state_t i_state,
  input  logic       i_start,
  input  logic       i_bit,
  output dms_state_t o_state_nxt,
  output logic       o_str_nxt,
  output logic       o_done_nxt
);

  localparam logic [DMS_CNT_W-1:0] ZLAST_ONE  =
    DMS_CNT_W'(SYM_LEN * DMS_RATIO_ONE / DMS_RATIO_DEN - 1);
  localparam logic [DMS_CNT_W-1:0] ZLAST_ZERO =
    DMS_CNT_W'(SYM_LEN * DMS_RATIO_ZERO / DMS_RATIO_DEN - 1);
  localparam logic [DMS_CNT_W-1:0] SYM_LAST   = DMS_CNT_W'(SYM_LEN - 1);

  logic [DMS_CNT_W-1:0] r_cnt;
  logic [DMS_CNT_W-1:0] w_cnt_nxt;
  logic                 r_bit;
  logic                 w_bit_nxt;
  logic [DMS_CNT_W-1:0] w_zero_last;

  assign w_zero_last = r_bit ? ZLAST_ONE : ZLAST_ZERO;

  // r_cnt runs 0..SYM_LEN-1 across the whole symbol, both runs included.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    o_state_nxt = i_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    case (i_state)
      ST_DATA_IDLE: begin
        if (i_start) begin
          o_state_nxt = ST_SYM_LO;
          w_cnt_nxt   = '0;
          w_bit_nxt   = i_bit;
        end
      end
      ST_SYM_LO: begin
        w_cnt_nxt = r_cnt + DMS_CNT_W'(1);
        if (r_cnt == w_zero_last) o_state_nxt = ST_SYM_HI;
      end
      ST_SYM_HI: begin
        if (r_cnt == SYM_LAST) begin
          if (i_start) begin
            o_state_nxt = ST_SYM_LO;
            w_cnt_nxt   = '0;
            w_bit_nxt   = i_bit;
          end else begin
            o_state_nxt = ST_DATA_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + DMS_CNT_W'(1);
        end
      end
      default: ;
    endcase
    o_str_nxt  = (o_state_nxt == ST_SYM_HI);
    o_done_nxt = o_str_nxt && (w_cnt_nxt == SYM_LAST);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
      r_bit <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all registers update together.
      r_cnt <= w_cnt_nxt;
      r_bit <= w_bit_nxt;
    end
  end

endmodule

// File: rtl/dms_sam_sequencer.sv
// SAM receiver front end: serialises one key set with sam_mode high, then
// streams message bits as pulse-width symbols. All outputs are registered.
module dms_sam_sequencer
  import dms_pkg::*;
#(
  parameter int SYM_LEN = 16,
  parameter int MAX_N   = DMS_MAX_N
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [DMS_N_W-1:0]   cfg_n,
  input  logic [DMS_KEY_W-1:0] cfg_d,
  input  logic [DMS_KEY_W-1:0] cfg_caps,
  output logic                 cfg_err,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic                 tx_bit,
  output logic                 sam_mode,
  output logic                 sam_str,
  output logic                 configured,
  output logic                 sym_done
);

  localparam logic [DMS_N_W-1:0] MAX_N_L = DMS_N_W'(MAX_N);

  dms_state_t           r_state, w_state_nxt, w_enc_state_nxt;
  logic [DMS_CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [DMS_N_W-1:0]   r_n, w_n_nxt;
  logic [DMS_KEY_W-1:0] r_d, w_d_nxt, r_caps, w_caps_nxt;
  logic                 r_cfg_err, w_err_nxt;
  logic                 r_cfg_ready, r_tx_ready, r_sam_mode, r_sam_str;
  logic                 r_configured, r_sym_done;
  logic                 w_str_nxt, w_enc_str_nxt, w_enc_done_nxt;
  logic                 w_cfg_hs, w_tx_hs;

  assign w_cfg_hs = cfg_valid && r_cfg_ready;
  assign w_tx_hs  = tx_valid && r_tx_ready;

  dms_sym_encoder #(.SYM_LEN(SYM_LEN)) u_enc (
    .clk        (clk),
    .reset      (reset),
    .i_state    (r_state),
    .i_start    (w_tx_hs),
    .i_bit      (tx_bit),
    .o_state_nxt(w_enc_state_nxt),
    .o_str_nxt  (w_enc_str_nxt),
    .o_done_nxt (w_enc_done_nxt)
  );

  // Load counters count down to 0 so the bit index is the counter itself.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_n_nxt     = r_n;
    w_d_nxt     = r_d;
    w_caps_nxt  = r_caps;
    w_err_nxt   = r_cfg_err;
    case (r_state)
      ST_IDLE: begin
        if (w_cfg_hs) begin
          if (cfg_n > MAX_N_L) begin
            w_err_nxt = 1'b1;
          end else begin
            w_n_nxt     = cfg_n;
            w_d_nxt     = cfg_d;
            w_caps_nxt  = cfg_caps;
            w_cnt_nxt   = DMS_CNT_W'(DMS_N_W - 1);
            w_state_nxt = ST_LOAD_N;
          end
        end
      end
      ST_LOAD_N: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_LOAD_D;
          w_cnt_nxt   = dms_key_last(r_n);
        end else begin
          w_cnt_nxt = r_cnt - DMS_CNT_W'(1);
        end
      end
      ST_LOAD_D: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_LOAD_C;
          w_cnt_nxt   = dms_key_last(r_n);
        end else begin
          w_cnt_nxt = r_cnt - DMS_CNT_W'(1);
        end
      end
      ST_LOAD_C: begin
        if (r_cnt == '0) w_state_nxt = ST_LOAD_END;
        else             w_cnt_nxt   = r_cnt - DMS_CNT_W'(1);
      end
      ST_LOAD_END: w_state_nxt = ST_DATA_IDLE;
      default:     w_state_nxt = w_enc_state_nxt;
    endcase

    case (w_state_nxt)
      ST_LOAD_N: w_str_nxt = w_n_nxt[w_cnt_nxt[1:0]];
      ST_LOAD_D: w_str_nxt = w_d_nxt[w_cnt_nxt[4:0]];
      ST_LOAD_C: w_str_nxt = w_caps_nxt[w_cnt_nxt[4:0]];
      default:   w_str_nxt = w_enc_str_nxt;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_n          <= '0;
      r_d          <= '0;
      r_caps       <= '0;
      r_cfg_err    <= 1'b0;
      r_cfg_ready  <= 1'b1;
      r_tx_ready   <= 1'b0;
      r_sam_mode   <= 1'b0;
      r_sam_str    <= 1'b0;
      r_configured <= 1'b0;
      r_sym_done   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_n          <= w_n_nxt;
      r_d          <= w_d_nxt;
      r_caps       <= w_caps_nxt;
      r_cfg_err    <= w_err_nxt;
      r_cfg_ready  <= (w_state_nxt == ST_IDLE);
      r_tx_ready   <= (w_state_nxt == ST_DATA_IDLE) || w_enc_done_nxt;
      r_sam_mode   <= dms_is_load(w_state_nxt);
      r_sam_str    <= w_str_nxt;
      r_configured <= dms_is_data(w_state_nxt);
      r_sym_done   <= w_enc_done_nxt;
    end
  end

  assign cfg_ready  = r_cfg_ready;
  assign cfg_err    = r_cfg_err;
  assign tx_ready   = r_tx_ready;
  assign sam_mode   = r_sam_mode;
  assign sam_str    = r_sam_str;
  assign configured = r_configured;
  assign sym_done   = r_sym_done;

endmodule

// File: tb/tb_dms_sam_sequencer.sv
// Self-checking bench for dms_sam_sequencer: table of key loads with expected
// serial streams, plus directed sequences for symbols, errors and mid-load reset.
module tb_dms_sam_sequencer;

  localparam int SYM_LEN = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [3:0]  cfg_n = '0;
  logic [31:0] cfg_d = '0;
  logic [31:0] cfg_caps = '0;
  logic        cfg_err;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic        tx_bit = 1'b0;
  logic        sam_mode;
  logic        sam_str;
  logic        configured;
  logic        sym_done;

  dms_sam_sequencer #(.SYM_LEN(SYM_LEN), .MAX_N(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_n     (cfg_n),
    .cfg_d     (cfg_d),
    .cfg_caps  (cfg_caps),
    .cfg_err   (cfg_err),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_bit    (tx_bit),
    .sam_mode  (sam_mode),
    .sam_str   (sam_str),
    .configured(configured),
    .sym_done  (sym_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  n;
    logic [31:0] d;
    logic [31:0] caps;
    logic [79:0] bits;   // expected sam_str stream, first cycle at bits[len-1]
    int          len;
    logic        sym;    // bit sent as one symbol after the load
  } load_vec_t;

  // {sam_mode, sam_str, cfg_ready, tx_ready, configured, cfg_err, sym_done}
  localparam logic [6:0] RESET_OUTS = 7'b0010000;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] outs();
    return {sam_mode, sam_str, cfg_ready, tx_ready, configured, cfg_err, sym_done};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    cfg_valid = 1'b0;
    tx_valid = 1'b0;
    tx_bit = 1'b0;
    #1;
    check("reset_outputs", 32'(outs()), 32'(RESET_OUTS));
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic do_load(input load_vec_t v, input logic hold_tx);
    cfg_valid = 1'b1;
    cfg_n = v.n;
    cfg_d = v.d;
    cfg_caps = v.caps;
    tx_valid = hold_tx;
    tx_bit = 1'b1;
    check("load_cfg_ready", 32'(cfg_ready), 32'd1);
    tick();
    cfg_valid = 1'b0;
    for (int i = 0; i < v.len; i++) begin
      check($sformatf("load_n%0d_str[%0d]", v.n, i), 32'(sam_str), 32'(v.bits[v.len-1-i]));
      check($sformatf("load_n%0d_ctl[%0d]", v.n, i),
            32'({sam_mode, cfg_ready, tx_ready, configured, sym_done}), 32'(5'b10000));
      tick();
    end
    check($sformatf("load_n%0d_done", v.n),
          32'({sam_mode, sam_str, cfg_ready, tx_ready, configured}), 32'(5'b00011));
  endtask

  // Expects the current cycle to have tx_ready=1; bits[0] is sent first.
  task automatic send_symbols(input int nsym, input logic [3:0] bits);
    int total;
    total = nsym * SYM_LEN + 1;
    tx_valid = 1'b1;
    tx_bit = bits[0];
    check("sym_start_ready", 32'(tx_ready), 32'd1);
    tick();
    for (int k = 0; k < total; k++) begin
      int   s, pos, z;
      logic e_str, e_done, e_ready;
      s = k / SYM_LEN;
      pos = k % SYM_LEN;
      if (s < nsym) begin
        z = bits[s] ? SYM_LEN / 4 : 3 * SYM_LEN / 4;
        e_str = (pos >= z);
        e_done = (pos == SYM_LEN - 1);
        e_ready = e_done;
      end else begin
        e_str = 1'b0;
        e_done = 1'b0;
        e_ready = 1'b1;
      end
      check($sformatf("sym%0d_pos%0d", s, pos),
            32'({sam_mode, sam_str, sym_done, tx_ready, configured}),
            32'({1'b0, e_str, e_done, e_ready, 1'b1}));
      if (pos == 0 && s < nsym) begin
        tx_valid = (s + 1 < nsym);
        if (s + 1 < nsym) tx_bit = bits[s+1];
      end
      tick();
    end
    tx_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    load_vec_t tbl [5];
    tbl[0] = '{n: 4'd2, d: 32'hA, caps: 32'h3,
               bits: 80'({4'b0010, 4'b1010, 4'b0011, 1'b0}), len: 13, sym: 1'b1};
    tbl[1] = '{n: 4'd1, d: 32'hFFFF_FFF2, caps: 32'h5,
               bits: 80'({4'b0001, 2'b10, 2'b01, 1'b0}), len: 9, sym: 1'b0};
    tbl[2] = '{n: 4'd0, d: 32'h1, caps: 32'h0,
               bits: 80'({4'b0000, 1'b1, 1'b0, 1'b0}), len: 7, sym: 1'b1};
    tbl[3] = '{n: 4'd3, d: 32'hC5, caps: 32'h3A,
               bits: 80'({4'b0011, 8'hC5, 8'h3A, 1'b0}), len: 21, sym: 1'b0};
    tbl[4] = '{n: 4'd5, d: 32'h8000_0001, caps: 32'h0F0F_F0F0,
               bits: 80'({4'b0101, 32'h8000_0001, 32'h0F0F_F0F0, 1'b0}), len: 69, sym: 1'b1};

    tick();
    tick();

    // Table: fresh reset, key load, one data symbol.
    for (int r = 0; r < 5; r++) begin
      apply_reset();
      check($sformatf("row%0d_idle_outputs", r), 32'(outs()), 32'(RESET_OUTS));
      do_load(tbl[r], 1'b0);
      send_symbols(1, {3'b000, tbl[r].sym});
    end

    // Back-to-back symbols 1,0 then 0,0,1; later cfg offers are ignored.
    apply_reset();
    do_load(tbl[0], 1'b0);
    send_symbols(2, 4'b0001);
    send_symbols(3, 4'b0100);
    cfg_valid = 1'b1;
    cfg_n = 4'd2;
    for (int i = 0; i < 20; i++) begin
      check($sformatf("recfg_ignored[%0d]", i),
            32'({sam_mode, cfg_ready, cfg_err, configured}), 32'(4'b0001));
      tick();
    end
    cfg_valid = 1'b0;

    // Oversized exponent: accepted with sticky error, then a legal load works.
    apply_reset();
    cfg_valid = 1'b1;
    cfg_n = 4'd6;
    cfg_d = 32'hFFFF_FFFF;
    cfg_caps = 32'hFFFF_FFFF;
    tick();
    cfg_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("bad_n_outputs[%0d]", i), 32'(outs()), 32'(7'b0010010));
      tick();
    end
    do_load(tbl[1], 1'b0);
    check("bad_n_err_sticky", 32'(cfg_err), 32'd1);

    // tx_valid held through the load: first symbol right after configuration.
    apply_reset();
    do_load(tbl[0], 1'b1);
    send_symbols(1, 4'b0001);

    // Reset in the 7th load cycle, then reload with n=0.
    apply_reset();
    cfg_valid = 1'b1;
    cfg_n = tbl[0].n;
    cfg_d = tbl[0].d;
    cfg_caps = tbl[0].caps;
    tick();
    cfg_valid = 1'b0;
    repeat (6) tick();
    check("midload_7th_cycle", 32'({sam_mode, sam_str}), 32'(2'b11));
    reset = 1'b0;
    #1;
    check("midload_reset_async", 32'(outs()), 32'(RESET_OUTS));
    tick();
    check("midload_reset_held", 32'(outs()), 32'(RESET_OUTS));
    reset = 1'b1;
    do_load(tbl[2], 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dms_sam_sequencer.md
# dms_sam_sequencer

Front-end controller for the SAM decryption receiver. It accepts a key set (n, d, capsN) over a valid/ready handshake and serialises it to the receiver's configuration port with `sam_mode` high. It then drops `sam_mode` and converts a stream of message bits, also delivered over valid/ready, into the pulse-width symbols the receiver decodes. It sits between the host/register side and the SAM instance and is the only driver of `sam_mode` and `sam_str`.

## Interface
- `SYM_LEN`, default 16: cycles per data symbol; legal range 12..60, must be a multiple of 4.
- `MAX_N`, default 5: largest accepted key exponent; 2^MAX_N must be ≤ 32.
- `clk` input 1: clock; all logic on posedge.
- `reset` input 1: asynchronous, active-low.
- `cfg_valid` input 1: key set offered.
- `cfg_ready` output 1: key set accepted when `cfg_valid && cfg_ready`.
- `cfg_n` input 4: key exponent n.
- `cfg_d` input 32: key d; only bits [2^n-1:0] are sent.
- `cfg_caps` input 32: capsN; only bits [2^n-1:0] are sent.
- `cfg_err` output 1: sticky; set when `cfg_n > MAX_N` is offered.
- `tx_valid` input 1: message bit offered.
- `tx_ready` output 1: message bit accepted when `tx_valid && tx_ready`.
- `tx_bit` input 1: message bit value.
- `sam_mode` output 1: receiver mode (1 = configure).
- `sam_str` output 1: receiver serial line.
- `configured` output 1: key load complete.
- `sym_done` output 1: one-cycle pulse on the last cycle of each data symbol.

## Operation
- States: IDLE, LOAD_N, LOAD_D, LOAD_C, LOAD_END, DATA_IDLE, SYM_LO, SYM_HI.
- IDLE: `cfg_ready=1`. On handshake with `cfg_n ≤ MAX_N`, latch n/d/caps and go to LOAD_N. With `cfg_n > MAX_N`: accept, set `cfg_err`, stay in IDLE.
- LOAD_N: 4 cycles; `sam_str` = n[3], n[2], n[1], n[0].
- LOAD_D: 2^n cycles; `sam_str` = d[2^n-1] down to d[0], MSB first.
- LOAD_C: 2^n cycles; same order for caps.
- LOAD_END: 1 cycle, `sam_str=0`. Then `configured` is set and the FSM goes to DATA_IDLE.
- `sam_mode=1` in every LOAD_* state and 0 in all other states.
- The key is accepted only once per reset. After leaving IDLE, `cfg_ready=0` until the next reset, because the receiver cannot be reloaded without a reset.
- DATA_IDLE: `sam_str=0`, `tx_ready=1`. A handshake latches `tx_bit` and enters SYM_LO.
- Symbol layout:
  - Zero run Z: `SYM_LEN/4` cycles for bit 1, `3*SYM_LEN/4` cycles for bit 0.
  - One run: the remaining `SYM_LEN-Z` cycles.
  - SYM_LO drives `sam_str=0` for Z cycles. SYM_HI drives `sam_str=1` for the rest.
- `tx_ready` is also 1 in the last SYM_HI cycle, which allows back-to-back symbols. On a handshake there, the next state is SYM_LO; otherwise it is DATA_IDLE.
- `sym_done` is high in the last SYM_HI cycle.
- Counters: a 6-bit symbol counter and a 6-bit load counter. Compute 2^n as `1<<n` in 6 bits; no wider arithmetic is needed.

## Timing
- Reset values:
  - `sam_mode=0`, `sam_str=0`, `cfg_ready=1`, `tx_ready=0`, `configured=0`, `cfg_err=0`, `sym_done=0`.
  - State = IDLE.
- All outputs are registered, so `sam_str` changes only after posedge.
- Load latency: first n bit on `sam_str` in the cycle after the cfg handshake. Load length is `5 + 2^(n+1)` cycles (n=2: 13).
- First symbol: its first zero appears in the cycle after the tx handshake.
- Symbol period: exactly `SYM_LEN` cycles with no gap between back-to-back symbols.
- `tx_valid` during LOAD_*: ignored, `tx_ready=0`.
- `cfg_valid` after configuration: ignored, `cfg_ready=0`, no error.
- Reset asserted mid-load or mid-symbol: immediate return to reset values. A new cfg handshake is required.
- n=0: LOAD_D and LOAD_C are one cycle each (bit [0] only).

## Structure
- Shared package `dms_pkg` holds:
  - the state enum,
  - `DMS_KEY_W=32`,
  - `DMS_N_W=4`,
  - `DMS_MAX_N=5`,
  - the symbol-ratio constants (1/4, 3/4).
- Sub-module `dms_sym_encoder`: bit in → SYM_LO/SYM_HI timing and `sym_done`; the main FSM owns configuration and the handshakes.

## Test plan
- Configure n=2, d=0xA, caps=0x3 → `sam_mode` high 13 cycles. `sam_str` = 0,0,1,0 | 1,0,1,0 | 0,0,1,1 | 0, then `configured=1`.
- `cfg_n=6` → `cfg_err=1`, state remains IDLE, `sam_mode` never rises. A following valid n=1 load still succeeds.
- `SYM_LEN=16`, send bit 1 then bit 0 back-to-back → `sam_str` shows 4×0, 12×1, 12×0, 4×1. `sym_done` pulses at cycles 16 and 32.
- `tx_valid` held high during the load → no handshake before `configured`. The first symbol starts the cycle after `configured` and its handshake.
- Reset pulsed in the 7th load cycle → all outputs return to reset values next edge. A reload with n=0, d=1, caps=0 produces 0,0,0,0,1,0,0 (7 cycles).
- Second `cfg_valid` after configuration → `cfg_ready` stays 0 and `sam_mode` stays 0 throughout.
